farbborg_scan_ctrl: RTL and testbench

Scan-out sequencer for the Farbborg framebuffer read port (7-bit address, 64-bit word, 1-cycle registered read).
- Walks 8 planes x 16 words per plane.
- Converts each byte to a PWM bit by comparing it against a step counter.
- Shifts 8 parallel lanes into the external LED driver chain, then latches and drives a one-hot plane select.
- Sits between the framebuffer RAM port B and the cube driver pins, in the RAM read clock domain.

---
 rtl/farbborg_scan_ctrl.sv | 160 ++++++++++++++++
 tb/tb_farbborg_scan_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/farbborg_scan_ctrl.sv
// Farbborg scan-out sequencer: framebuffer words -> PWM bits -> LED driver chain.
// Optional FARBBORG_GAMMA_EN applies a quadratic gamma to each byte before the PWM compare.
module farbborg_scan_ctrl #(
  parameter int unsigned STEP_DIV = 16,
  parameter int unsigned PWM_MAX  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [6:0]  ram_addr,
  input  logic [63:0] ram_data,
  output logic [7:0]  sd,
  output logic        sclk,
  output logic        latch,
  output logic [7:0]  plane_sel,
  output logic        blank,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWait,
    StData,
    StClk,
    StLatch,
    StHold
  } state_e;

  localparam int unsigned HoldW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(STEP_DIV - 1);
  localparam logic [7:0] PwmLast = 8'(PWM_MAX - 1);

  state_e           state_q, state_d;
  logic [2:0]       plane_q, plane_d;
  logic [3:0]       word_q, word_d;
  logic [7:0]       pwm_q, pwm_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [6:0]       addr_q, addr_d;
  logic [7:0]       sd_q, sd_d;
  logic [7:0]       psel_q, psel_d;
  logic             sclk_q, sclk_d;
  logic             latch_q, latch_d;
  logic             blank_q, blank_d;
  logic             fd_q, fd_d;
  logic [7:0]       sd_cmp;

  function automatic logic [7:0] cmp_value(input logic [7:0] b);
`ifdef FARBBORG_GAMMA_EN
    logic [15:0] sq;
    sq = 16'(b) * 16'(b);
    return sq[15:8];
`else
    return b;
`endif
  endfunction

  always_comb begin
    sd_cmp = '0;
    for (int i = 0; i < 8; i++) begin
      sd_cmp[i] = cmp_value(ram_data[8*i +: 8]) > pwm_q;
    end
  end

  always_comb begin
    state_d = state_q;
    plane_d = plane_q;
    word_d  = word_q;
    pwm_d   = pwm_q;
    hold_d  = hold_q;
    addr_d  = addr_q;
    sd_d    = sd_q;
    psel_d  = psel_q;
    fd_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StAddr;
      end
      StAddr: begin
        addr_d  = {plane_q, word_q};
        state_d = StWait;
      end
      StWait: state_d = StData;
      StData: begin
        sd_d    = sd_cmp;
        state_d = StClk;
      end
      StClk: begin
        if (word_q == 4'hF) begin
          word_d  = '0;
          state_d = StLatch;
          // Registered so the pulse lands in the same cycle as latch.
          fd_d    = (pwm_q == PwmLast) && (plane_q == 3'd7);
        end else begin
          word_d  = word_q + 4'd1;
          state_d = StAddr;
        end
      end
      StLatch: begin
        if (pwm_q == PwmLast) begin
          pwm_d   = '0;
          plane_d = plane_q + 3'd1;
          psel_d  = {psel_q[6:0], psel_q[7]};
        end else begin
          pwm_d = pwm_q + 8'd1;
        end
        hold_d  = '0;
        state_d = StHold;
      end
      StHold: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HoldLast) state_d = enable ? StAddr : StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Strobes decode the next state so every pin comes straight from a flop.
    sclk_d  = (state_d == StClk);
    latch_d = (state_d == StLatch);
    blank_d = (state_d != StHold);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      plane_q <= '0;
      word_q  <= '0;
      pwm_q   <= '0;
      hold_q  <= '0;
      addr_q  <= '0;
      sd_q    <= '0;
      psel_q  <= 8'h01;
      sclk_q  <= 1'b0;
      latch_q <= 1'b0;
      blank_q <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      plane_q <= plane_d;
      word_q  <= word_d;
      pwm_q   <= pwm_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
      sd_q    <= sd_d;
      psel_q  <= psel_d;
      sclk_q  <= sclk_d;
      latch_q <= latch_d;
      blank_q <= blank_d;
      fd_q    <= fd_d;
    end
  end

  assign ram_addr   = addr_q;
  assign sd         = sd_q;
  assign sclk       = sclk_q;
  assign latch      = latch_q;
  assign plane_sel  = psel_q;
  assign blank      = blank_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_farbborg_scan_ctrl.sv
// Directed bench for farbborg_scan_ctrl with a registered-read RAM model.
// Expected sd values switch with FARBBORG_GAMMA_EN.
module tb_farbborg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [6:0]  ram_addr;
  logic [63:0] ram_data;
  logic [7:0]  sd;
  logic        sclk;
  logic        latch;
  logic [7:0]  plane_sel;
  logic        blank;
  logic        frame_done;

  farbborg_scan_ctrl #(
    .STEP_DIV(16),
    .PWM_MAX (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .sd        (sd),
    .sclk      (sclk),
    .latch     (latch),
    .plane_sel (plane_sel),
    .blank     (blank),
    .frame_done(frame_done)
  );

`ifdef FARBBORG_GAMMA_EN
  localparam logic [7:0] ExpW5S0 = 8'h40;
  localparam logic [7:0] ExpW6S0 = 8'h01;
  localparam logic [7:0] ExpW6S1 = 8'h00;
`else
  localparam logic [7:0] ExpW5S0 = 8'h41;
  localparam logic [7:0] ExpW6S0 = 8'h03;
  localparam logic [7:0] ExpW6S1 = 8'h03;
`endif

  logic [63:0] mem [128];
  always @(posedge clk) ram_data <= mem[ram_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event log captured mid-cycle.
  int         cyc = 0;
  int         sclk_cnt = 0;
  int         latch_cnt = 0;
  int         fd_cnt = 0;
  int         fd_idx = 0;
  int         fd_stray = 0;
  int         blank_lo = 0;
  logic       latch_prev = 1'b0;
  logic [7:0] sd_log [512];
  logic [6:0] addr_log [512];
  logic [7:0] psel_log [64];
  int         latch_cyc [64];

  always @(negedge clk) begin
    cyc++;
    if (sclk && sclk_cnt < 512) begin
      sd_log[sclk_cnt]   = sd;
      addr_log[sclk_cnt] = ram_addr;
      sclk_cnt++;
    end
    if (latch_prev && latch_cnt < 64) psel_log[latch_cnt] = plane_sel;
    latch_prev = latch;
    if (latch && latch_cnt < 63) begin
      latch_cnt++;
      latch_cyc[latch_cnt] = cyc;
    end
    if (frame_done) begin
      if (latch) begin
        fd_cnt++;
        fd_idx = latch_cnt;
      end else begin
        fd_stray++;
      end
    end
    if (!blank) blank_lo++;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_latch(input int target, input int budget, input string tag);
    int n = 0;
    while (latch_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(latch_cnt >= target), 64'd1);
  endtask

  task automatic wait_sclk(input int target, input int budget, input string tag);
    int n = 0;
    while (sclk_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(sclk_cnt >= target), 64'd1);
  endtask

  initial begin
    for (int a = 0; a < 128; a++) mem[a] = {8{8'h80}};
    mem[5] = 64'h00FF_0000_0000_0001;
    mem[6] = 64'h0000_0000_0000_0F10;
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) tick();

    check("rst_ram_addr", 64'(ram_addr), 64'h0);
    check("rst_sd", 64'(sd), 64'h0);
    check("rst_sclk", 64'(sclk), 64'h0);
    check("rst_latch", 64'(latch), 64'h0);
    check("rst_plane_sel", 64'(plane_sel), 64'h01);
    check("rst_blank", 64'(blank), 64'h1);
    check("rst_frame_done", 64'(frame_done), 64'h0);

    rst_n = 1'b1;
    repeat (100) tick();
    check("idle_sclk_cnt", 64'(sclk_cnt), 64'd0);
    check("idle_latch_cnt", 64'(latch_cnt), 64'd0);
    check("idle_blank", 64'(blank), 64'h1);
    check("idle_ram_addr", 64'(ram_addr), 64'h0);

    // Single-cycle enable pulse runs exactly one row, then back to idle.
    enable = 1'b1;
    tick();
    enable = 1'b0;
    wait_latch(1, 200, "row0_latch_timeout");
    repeat (40) tick();
    check("row0_sclk_cnt", 64'(sclk_cnt), 64'd16);
    check("row0_latch_cnt", 64'(latch_cnt), 64'd1);
    check("row0_w0_sd", 64'(sd_log[0]), 64'hFF);
    check("row0_w5_sd", 64'(sd_log[5]), 64'(ExpW5S0));
    check("row0_w6_sd", 64'(sd_log[6]), 64'(ExpW6S0));
    check("row0_w5_addr", 64'(addr_log[5]), 64'h05);
    check("row0_psel", 64'(psel_log[1]), 64'h01);
    check("row0_blank_after", 64'(blank), 64'h1);
    check("row0_hold_len", 64'(blank_lo), 64'd16);
    check("row0_no_fd", 64'(fd_cnt), 64'd0);

    // Continuous run through a full frame.
    enable = 1'b1;
    wait_latch(17, 17 * 81 + 200, "frame_latch_timeout");
    check("row1_w0_sd", 64'(sd_log[16]), 64'hFF);
    check("row1_w5_sd", 64'(sd_log[21]), 64'h40);
    check("row1_w6_sd", 64'(sd_log[22]), 64'(ExpW6S1));
    check("row_period", 64'(latch_cyc[3] - latch_cyc[2]), 64'd81);
    check("row2_addr_w0", 64'(addr_log[32]), 64'h10);
    check("psel_after_l2", 64'(psel_log[2]), 64'h02);
    check("psel_after_l4", 64'(psel_log[4]), 64'h04);
    check("psel_after_l14", 64'(psel_log[14]), 64'h80);
    check("psel_after_l16", 64'(psel_log[16]), 64'h01);
    check("fd_count", 64'(fd_cnt), 64'd1);
    check("fd_at_latch16", 64'(fd_idx), 64'd16);
    check("fd_stray", 64'(fd_stray), 64'd0);

    // Drop enable after word 7 of row 17: the row must still complete.
    wait_sclk(272 + 8, 200, "drop_sclk_timeout");
    enable = 1'b0;
    wait_latch(18, 200, "drop_latch_timeout");
    repeat (40) tick();
    check("drop_sclk_cnt", 64'(sclk_cnt), 64'd288);
    check("drop_latch_cnt", 64'(latch_cnt), 64'd18);
    check("drop_blank", 64'(blank), 64'h1);
    check("drop_hold_total", 64'(blank_lo), 64'd288);
    check("drop_w5_sd", 64'(sd_log[277]), 64'h40);
    check("drop_psel", 64'(psel_log[18]), 64'h02);

    // Resume continues with plane 1.
    enable = 1'b1;
    wait_latch(19, 200, "resume_latch_timeout");
    check("resume_addr_w0", 64'(addr_log[288]), 64'h10);
    check("resume_addr_w15", 64'(addr_log[303]), 64'h1F);
    check("resume_sd_w0", 64'(sd_log[288]), 64'hFF);

    // Reset in the middle of a latch pulse.
    begin
      int n = 0;
      while (!latch && n < 200) begin
        tick();
        n++;
      end
    end
    check("latch_seen_before_rst", 64'(latch), 64'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_latch", 64'(latch), 64'h0);
    check("midrst_sclk", 64'(sclk), 64'h0);
    check("midrst_plane_sel", 64'(plane_sel), 64'h01);
    check("midrst_blank", 64'(blank), 64'h1);
    check("midrst_ram_addr", 64'(ram_addr), 64'h0);
    check("midrst_sd", 64'(sd), 64'h0);
    begin
      int s0;
      s0 = sclk_cnt;
      repeat (5) tick();
      check("midrst_no_sclk", 64'(sclk_cnt), 64'(s0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
